pc_trap_r32: RTL

Parametrised next-generation program counter for the RV32I core. It supports conditional, unconditional, relative and absolute branches, optional 16-bit (compressed) instruction increments, instruction-cache stalls, and a single-level trap/return mechanism with a saved exception PC. It detects misaligned branch targets and escalates a nested trap to a halted state. It sits between the decode/branch-compare logic and the instruction cache address port.

---
 rtl/pc_trap_r32.sv | 95 +++++++++
 1 files changed

// File: rtl/pc_trap_r32.sv
// Program counter for the RV32I core: sequential/compressed increments, branches,
// instruction-cache stalls and a single-level trap/return with nested-trap halt.
//
// state   | meaning
// RUN     | normal execution
// HANDLER | executing the trap handler; EPC holds the interrupted PC
// HALT    | nested trap seen; everything frozen until reset
module pc_trap_r32 #(
    parameter int          dataW        = 32,
    parameter int unsigned ResetAddr    = 16,
    parameter int unsigned TrapVector   = 256,
    parameter int          CompressedEn = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             EQ,
    input  logic             NE,
    input  logic             LT,
    input  logic             LTU,
    input  logic             GE,
    input  logic             GEU,
    input  logic             TestBranch,
    input  logic             AlwaysBranch,
    input  logic             AbsoluteBranch,
    input  logic [2:0]       BranchType,
    input  logic [dataW-1:0] BranchAddr,
    input  logic             InsLen16,
    input  logic             InsCacheStall,
    input  logic             TrapReq,
    input  logic             TrapRet,
    output logic [dataW-1:0] ProgAddr,
    output logic [dataW-1:0] LinkAddr,
    output logic [dataW-1:0] EPC,
    output logic             InHandler,
    output logic             Halted,
    output logic             MisalignFault
);

    typedef enum logic [1:0] {RUN, HANDLER, HALT} state_t;

    localparam logic             compEn     = (CompressedEn != 0);
    localparam logic [dataW-1:0] resetVal   = dataW'(ResetAddr);
    localparam logic [dataW-1:0] trapVal    = dataW'(TrapVector);

    state_t           state;
    logic [7:0]       flags;
    logic             taken;
    logic             misaligned;
    logic [dataW-1:0] offset;
    logic [dataW-1:0] tgt;
    logic [dataW-1:0] incr;

    // Types 6 and 7 index the zero-padded top bits, so they are never taken.
    assign flags      = {2'b00, GEU, GE, LTU, LT, NE, EQ};
    assign taken      = AlwaysBranch || (TestBranch && flags[BranchType]);
    assign offset     = BranchAddr & ~dataW'(1);
    assign tgt        = AbsoluteBranch ? offset : ProgAddr + offset;
    assign misaligned = taken && !compEn && tgt[1];
    assign incr       = (compEn && InsLen16) ? dataW'(2) : dataW'(4);

    assign LinkAddr   = ProgAddr + incr;
    assign InHandler  = (state == HANDLER);
    assign Halted     = (state == HALT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ProgAddr      <= resetVal;
            EPC           <= '0;
            state         <= RUN;
            MisalignFault <= 1'b0;
        end else begin
            MisalignFault <= 1'b0;
            if (!InsCacheStall && state != HALT) begin
                if (TrapReq || misaligned) begin
                    if (state == RUN) begin
                        EPC           <= ProgAddr;
                        ProgAddr      <= trapVal;
                        state         <= HANDLER;
                        MisalignFault <= misaligned && !TrapReq;
                    end else begin
                        state <= HALT;
                    end
                end else if (TrapRet && state == HANDLER) begin
                    ProgAddr <= EPC;
                    state    <= RUN;
                end else if (taken) begin
                    ProgAddr <= tgt;
                end else begin
                    ProgAddr <= ProgAddr + incr;
                end
            end
        end
    end

endmodule
